// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: data widths, reset/exception addresses,
// legal text pages, exception codes, NPCOp encodings and the FSM encoding.
package cpu_defs;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PAGE_W  = 20;
  localparam int unsigned EXC_W   = 5;
  localparam int unsigned NPCOP_W = 2;

  localparam logic [XLEN-1:0]   RESET_PC    = 32'h0000_3000;
  localparam logic [XLEN-1:0]   EXC_VEC     = 32'h0000_4180;
  localparam logic [PAGE_W-1:0] TEXT_PAGE_A = 20'h0000_3;
  localparam logic [PAGE_W-1:0] TEXT_PAGE_B = 20'h0000_4;

  localparam logic [EXC_W-1:0]  EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0]  EXC_ADEL = 5'd4;

  typedef enum logic [NPCOP_W-1:0] {
    NPC_PC4    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JREG   = 2'b11
  } npc_op_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory req/ack bus between the fetch controller (master)
// and the memory bridge (slave).
//   imem_req   : fetch request
//   imem_addr  : word-aligned fetch address, stable while a request is held
//   imem_ack   : read data valid, may coincide with the first request cycle
//   imem_rdata : instruction word
interface fetch_ctrl_if;
  import cpu_defs::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ack, input  imem_rdata);
  modport slave  (input  imem_req, input  imem_addr,
                  output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_ctrl_addr_chk.sv
// Fetch-address fault check: flags a misaligned pc or a pc outside both
// legal text pages.
//   pc_page_i  : pc[31:12]
//   pc_align_i : pc[1:0]
//   bad_o      : address must not be fetched (AdEL)
module fetch_addr_chk #(
  parameter logic [cpu_defs::PAGE_W-1:0] PAGE_A = cpu_defs::TEXT_PAGE_A,
  parameter logic [cpu_defs::PAGE_W-1:0] PAGE_B = cpu_defs::TEXT_PAGE_B
) (
  input  logic [cpu_defs::PAGE_W-1:0] pc_page_i,
  input  logic [1:0]                  pc_align_i,
  output logic                        bad_o
);

  assign bad_o = (pc_align_i != 2'b00) ||
                 ((pc_page_i != PAGE_A) && (pc_page_i != PAGE_B));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for a variable-latency instruction memory.
// Owns the PC, the one-entry IF/ID buffer, next-PC selection (sequential,
// branch after delay slot, exception vector, EPC return) and the AdEL check.
//   clk, reset            : clock, async active-high reset
//   stall_ID              : ID cannot accept, buffer held
//   NPCOp_ID, npcValue_ID : taken jump/branch of the instruction in ID
//   flush                 : exception entry, redirect to EXC_VEC
//   epc_WE, epcValue_MEM  : eret, redirect to the EPC value
//   imem                  : req/ack memory bus (master side)
//   Instr_IF, pcValue_IF  : buffered instruction and its PC
//   valid_IF              : buffer holds an instruction
//   ExcCode_out           : AdEL (4) on fetch fault, else 0
module fetch_ctrl #(
  parameter logic [cpu_defs::XLEN-1:0]   RESET_PC    = cpu_defs::RESET_PC,
  parameter logic [cpu_defs::XLEN-1:0]   EXC_VEC     = cpu_defs::EXC_VEC,
  parameter logic [cpu_defs::PAGE_W-1:0] TEXT_PAGE_A = cpu_defs::TEXT_PAGE_A,
  parameter logic [cpu_defs::PAGE_W-1:0] TEXT_PAGE_B = cpu_defs::TEXT_PAGE_B
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall_ID,
  input  logic [cpu_defs::NPCOP_W-1:0]  NPCOp_ID,
  input  logic [cpu_defs::XLEN-1:0]     npcValue_ID,
  input  logic                          flush,
  input  logic                          epc_WE,
  input  logic [cpu_defs::XLEN-1:0]     epcValue_MEM,
  fetch_ctrl_if.master                  imem,
  output logic [cpu_defs::XLEN-1:0]     Instr_IF,
  output logic [cpu_defs::XLEN-1:0]     pcValue_IF,
  output logic                          valid_IF,
  output logic [cpu_defs::EXC_W-1:0]    ExcCode_out
);
  import cpu_defs::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] br_tgt_q, br_tgt_d;
  logic            pend_br_q, pend_br_d;
  logic [XLEN-1:0] rd_tgt_q, rd_tgt_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pcv_q, pcv_d;
  logic [EXC_W-1:0] exc_q, exc_d;

  logic            bad_pc;
  logic            buf_free;
  logic            redirect;
  logic            br_take;
  logic            req_c;
  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] drain_tgt;
  logic [XLEN-1:0] seq_pc;

  fetch_addr_chk #(
    .PAGE_A (TEXT_PAGE_A),
    .PAGE_B (TEXT_PAGE_B)
  ) u_addr_chk (
    .pc_page_i  (pc_q[XLEN-1:12]),
    .pc_align_i (pc_q[1:0]),
    .bad_o      (bad_pc)
  );

  // Next-state, buffer and request logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    br_tgt_d  = br_tgt_q;
    pend_br_d = pend_br_q;
    rd_tgt_d  = rd_tgt_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    pcv_d     = pcv_q;
    exc_d     = exc_q;
    req_c     = 1'b0;

    buf_free  = !valid_q || !stall_ID;
    redirect  = epc_WE || flush;
    redir_tgt = epc_WE ? epcValue_MEM : EXC_VEC;
    drain_tgt = redirect ? redir_tgt : rd_tgt_q;
    br_take   = valid_q && !stall_ID && (NPCOp_ID != NPC_PC4) && !redirect;
    // A branch leaving ID in the same cycle its delay slot is fetched must
    // steer this very advance, so the fresh target bypasses pend_br.
    seq_pc    = br_take   ? npcValue_ID :
                pend_br_q ? br_tgt_q    : pc_q + XLEN'(4);

    if (valid_q && !stall_ID) valid_d = 1'b0;

    if (br_take) begin
      pend_br_d = 1'b1;
      br_tgt_d  = npcValue_ID;
    end

    case (state_q)
      ST_FETCH: begin
        if (redirect) begin
          pc_d = redir_tgt;
        end else if (buf_free) begin
          if (bad_pc) begin
            valid_d   = 1'b1;
            instr_d   = '0;
            pcv_d     = pc_q;
            exc_d     = EXC_ADEL;
            pc_d      = seq_pc;
            pend_br_d = 1'b0;
          end else begin
            req_c = 1'b1;
            if (imem.imem_ack) begin
              valid_d   = 1'b1;
              instr_d   = imem.imem_rdata;
              pcv_d     = pc_q;
              exc_d     = EXC_NONE;
              pc_d      = seq_pc;
              pend_br_d = 1'b0;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        req_c = 1'b1;
        if (redirect) begin
          if (imem.imem_ack) begin
            pc_d    = redir_tgt;
            state_d = ST_FETCH;
          end else begin
            rd_tgt_d = redir_tgt;
            state_d  = ST_DRAIN;
          end
        end else if (imem.imem_ack) begin
          valid_d   = 1'b1;
          instr_d   = imem.imem_rdata;
          pcv_d     = pc_q;
          exc_d     = EXC_NONE;
          pc_d      = seq_pc;
          pend_br_d = 1'b0;
          state_d   = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        // Stale request: wait out the ack, drop the data, then redirect.
        req_c = 1'b1;
        if (imem.imem_ack) begin
          pc_d    = drain_tgt;
          state_d = ST_FETCH;
        end else begin
          rd_tgt_d = drain_tgt;
        end
      end
      default: state_d = ST_FETCH;
    endcase

    if (redirect) begin
      valid_d   = 1'b0;
      pend_br_d = 1'b0;
    end
  end

  // State and buffer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      br_tgt_q  <= '0;
      pend_br_q <= 1'b0;
      rd_tgt_q  <= '0;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pcv_q     <= '0;
      exc_q     <= EXC_NONE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      br_tgt_q  <= br_tgt_d;
      pend_br_q <= pend_br_d;
      rd_tgt_q  <= rd_tgt_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pcv_q     <= pcv_d;
      exc_q     <= exc_d;
    end
  end

  // Request is decoded from state so a same-cycle ack gives full throughput.
  assign imem.imem_req  = req_c && !reset;
  assign imem.imem_addr = pc_q;

  assign Instr_IF    = instr_q;
  assign pcValue_IF  = pcv_q;
  assign valid_IF    = valid_q;
  assign ExcCode_out = exc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: cycle table with an always-acking memory, hand
// sequences for wait-state and flush-while-outstanding, then random traffic
// checked against an instruction-stream model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_ID;
  logic [1:0]  NPCOp_ID;
  logic [31:0] npcValue_ID;
  logic        flush;
  logic        epc_WE;
  logic [31:0] epcValue_MEM;
  logic [31:0] Instr_IF;
  logic [31:0] pcValue_IF;
  logic        valid_IF;
  logic [4:0]  ExcCode_out;

  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .stall_ID     (stall_ID),
    .NPCOp_ID     (NPCOp_ID),
    .npcValue_ID  (npcValue_ID),
    .flush        (flush),
    .epc_WE       (epc_WE),
    .epcValue_MEM (epcValue_MEM),
    .imem         (bus),
    .Instr_IF     (Instr_IF),
    .pcValue_IF   (pcValue_IF),
    .valid_IF     (valid_IF),
    .ExcCode_out  (ExcCode_out)
  );

  always #5 clk = ~clk;

  // Memory model: ack after 'lat' held-request cycles, data derived from address
  logic [3:0] wcnt;
  logic [3:0] lat;
  logic [3:0] fixed_lat = 4'd0;
  logic       rand_mode = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  assign bus.imem_ack   = bus.imem_req && (wcnt >= lat);
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt <= 4'd0;
      lat  <= fixed_lat;
    end else if (bus.imem_req && bus.imem_ack) begin
      wcnt <= 4'd0;
      lat  <= rand_mode ? 4'($urandom_range(0, 3)) : fixed_lat;
    end else if (bus.imem_req) begin
      wcnt <= wcnt + 4'd1;
    end else begin
      wcnt <= 4'd0;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a[31:12] != 20'h00003) && (a[31:12] != 20'h00004));
  endfunction

  function automatic logic [31:0] rand_tgt();
    int unsigned r;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'h0000_5000 + {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    if (r == 1) return {20'h00003, 10'($urandom_range(0, 1023)), 2'b10};
    if (r == 2) return 32'hFFFF_FFFC;
    return {20'h00003 + 20'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 2'b00};
  endfunction

  task automatic idle_inputs();
    stall_ID = 1'b0; NPCOp_ID = 2'b00; npcValue_ID = 32'h0;
    flush = 1'b0; epc_WE = 1'b0; epcValue_MEM = 32'h0;
  endtask

  // Reset and check reset values; returns at a falling edge with reset released
  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_valid", 32'(valid_IF), 32'd0);
    check("rst_instr", Instr_IF, 32'h0);
    check("rst_pcv", pcValue_IF, 32'h0);
    check("rst_exc", 32'(ExcCode_out), 32'd0);
    check("rst_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        stall;
    logic [1:0]  op;
    logic [31:0] npc;
    logic        fl;
    logic        ew;
    logic [31:0] epcv;
    logic        x_valid;
    logic        x_chkbuf;
    logic [31:0] x_pcv;
    logic [4:0]  x_exc;
    logic        x_req;
    logic [31:0] x_addr;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [1:0] op, input logic [31:0] npc,
                              input logic fl, input logic ew, input logic [31:0] epcv,
                              input logic xv, input logic xb, input logic [31:0] xpcv,
                              input logic [4:0] xexc, input logic xreq, input logic [31:0] xaddr);
    vec_t v;
    v.stall = st; v.op = op; v.npc = npc; v.fl = fl; v.ew = ew; v.epcv = epcv;
    v.x_valid = xv; v.x_chkbuf = xb; v.x_pcv = xpcv; v.x_exc = xexc;
    v.x_req = xreq; v.x_addr = xaddr;
    return v;
  endfunction

  vec_t tv [18];

  logic        found;
  logic [31:0] exp_pc, m_tgt, hold_addr;
  logic        m_pend, hold;
  int          delivered;

  initial begin
    reset = 1'b0;
    idle_inputs();

    //        stall op  npc         fl ew epcv        | v  b  pcv         exc req addr
    tv[0]  = mk(0, 2'd0, 32'h0,     0, 0, 32'h0,        0, 0, 32'h0,     5'd0, 1, 32'h3000);
    tv[1]  = mk(0, 2'd0, 32'h0,     0, 0, 32'h0,        1, 1, 32'h3000,  5'd0, 1, 32'h3004);
    tv[2]  = mk(0, 2'd0, 32'h0,     0, 0, 32'h0,        1, 1, 32'h3004,  5'd0, 1, 32'h3008);
    tv[3]  = mk(0, 2'd1, 32'h3100,  0, 0, 32'h0,        1, 1, 32'h3008,  5'd0, 1, 32'h300C);
    tv[4]  = mk(0, 2'd0, 32'h0,     0, 0, 32'h0,        1, 1, 32'h300C,  5'd0, 1, 32'h3100);
    tv[5]  = mk(0, 2'd0, 32'h0,     0, 0, 32'h0,        1, 1, 32'h3100,  5'd0, 1, 32'h3104);
    tv[6]  = mk(1, 2'd0, 32'h0,     0, 0, 32'h0,        1, 1, 32'h3104,  5'd0, 0, 32'h3108);
    tv[7]  = mk(0, 2'd0, 32'h0,     0, 0, 32'h0,        1, 1, 32'h3104,  5'd0, 1, 32'h3108);
    tv[8]  = mk(0, 2'd0, 32'h0,     1, 1, 32'h3020,     1, 1, 32'h3108,  5'd0, 0, 32'h310C);
    tv[9]  = mk(0, 2'd0, 32'h0,     0, 0, 32'h0,        0, 0, 32'h0,     5'd0, 1, 32'h3020);
    tv[10] = mk(0, 2'd2, 32'h5000,  0, 0, 32'h0,        1, 1, 32'h3020,  5'd0, 1, 32'h3024);
    tv[11] = mk(0, 2'd0, 32'h0,     0, 0, 32'h0,        1, 1, 32'h3024,  5'd0, 0, 32'h5000);
    tv[12] = mk(1, 2'd0, 32'h0,     0, 0, 32'h0,        1, 1, 32'h5000,  5'd4, 0, 32'h5004);
    tv[13] = mk(1, 2'd0, 32'h0,     0, 0, 32'h0,        1, 1, 32'h5000,  5'd4, 0, 32'h5004);
    tv[14] = mk(0, 2'd1, 32'h3002,  0, 0, 32'h0,        1, 1, 32'h5000,  5'd4, 0, 32'h5004);
    tv[15] = mk(0, 2'd0, 32'h0,     0, 0, 32'h0,        1, 1, 32'h5004,  5'd4, 0, 32'h3002);
    tv[16] = mk(1, 2'd0, 32'h0,     0, 0, 32'h0,        1, 1, 32'h3002,  5'd4, 0, 32'h3006);
    tv[17] = mk(1, 2'd0, 32'h0,     0, 0, 32'h0,        1, 1, 32'h3002,  5'd4, 0, 32'h3006);

    // Same-cycle ack: streaming, branch delay slot, stall, redirect, faults
    fixed_lat = 4'd0;
    rand_mode = 1'b0;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      stall_ID = tv[i].stall; NPCOp_ID = tv[i].op; npcValue_ID = tv[i].npc;
      flush = tv[i].fl; epc_WE = tv[i].ew; epcValue_MEM = tv[i].epcv;
      #1;
      check($sformatf("tv%0d_valid", i), 32'(valid_IF), 32'(tv[i].x_valid));
      check($sformatf("tv%0d_req", i), 32'(bus.imem_req), 32'(tv[i].x_req));
      check($sformatf("tv%0d_addr", i), bus.imem_addr, tv[i].x_addr);
      if (tv[i].x_chkbuf) begin
        check($sformatf("tv%0d_pcv", i), pcValue_IF, tv[i].x_pcv);
        check($sformatf("tv%0d_exc", i), 32'(ExcCode_out), 32'(tv[i].x_exc));
        check($sformatf("tv%0d_instr", i), Instr_IF,
              (tv[i].x_exc == 5'd4) ? 32'h0 : mem_word(tv[i].x_pcv));
      end
      @(negedge clk);
    end

    // Two wait states: address held three cycles, two bubbles per fetch
    fixed_lat = 4'd2;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      #1;
      if (c < 3) begin
        check($sformatf("lat_c%0d_req", c), 32'(bus.imem_req), 32'd1);
        check($sformatf("lat_c%0d_addr", c), bus.imem_addr, 32'h3000);
        check($sformatf("lat_c%0d_valid", c), 32'(valid_IF), 32'd0);
      end else if (c == 3 || c == 6) begin
        check($sformatf("lat_c%0d_valid", c), 32'(valid_IF), 32'd1);
        check($sformatf("lat_c%0d_pcv", c), pcValue_IF, (c == 3) ? 32'h3000 : 32'h3004);
        check($sformatf("lat_c%0d_instr", c), Instr_IF,
              mem_word((c == 3) ? 32'h3000 : 32'h3004));
      end else begin
        check($sformatf("lat_c%0d_bubble", c), 32'(valid_IF), 32'd0);
        check($sformatf("lat_c%0d_addr", c), bus.imem_addr, 32'h3004);
      end
      @(negedge clk);
    end

    // Flush while the request to 0x3010 is outstanding
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      #1;
      if (bus.imem_req && bus.imem_addr == 32'h3010) found = 1'b1;
      else @(negedge clk);
    end
    check("fl_reach_3010", 32'(found), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("fl_wait_addr", bus.imem_addr, 32'h3010);
    check("fl_wait_ack", 32'(bus.imem_ack), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fl_drain_req", 32'(bus.imem_req), 32'd1);
    check("fl_drain_addr", bus.imem_addr, 32'h3010);
    check("fl_drain_valid", 32'(valid_IF), 32'd0);
    @(negedge clk);
    #1;
    check("fl_vec_req", 32'(bus.imem_req), 32'd1);
    check("fl_vec_addr", bus.imem_addr, 32'h4180);
    check("fl_vec_valid", 32'(valid_IF), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("fl_discard%0d", c), 32'(valid_IF), 32'd0);
    end
    @(negedge clk);
    #1;
    check("fl_first_valid", 32'(valid_IF), 32'd1);
    check("fl_first_pcv", pcValue_IF, 32'h4180);
    check("fl_first_instr", Instr_IF, mem_word(32'h4180));
    @(negedge clk);

    // Random traffic against the program-order stream model
    rand_mode = 1'b1;
    fixed_lat = 4'd1;
    do_reset();
    exp_pc = 32'h3000; m_pend = 1'b0; m_tgt = 32'h0;
    hold = 1'b0; hold_addr = 32'h0; delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      stall_ID = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 39) == 0);
      epc_WE = ($urandom_range(0, 49) == 0);
      epcValue_MEM = rand_tgt();
      if (!m_pend && $urandom_range(0, 5) == 0) begin
        NPCOp_ID = 2'($urandom_range(1, 3));
        npcValue_ID = rand_tgt();
      end else begin
        NPCOp_ID = 2'b00;
        npcValue_ID = $urandom;
      end
      #1;
      if (hold) begin
        check("rnd_req_held", 32'(bus.imem_req), 32'd1);
        check("rnd_addr_stable", bus.imem_addr, hold_addr);
      end
      hold = bus.imem_req && !bus.imem_ack;
      hold_addr = bus.imem_addr;
      if (valid_IF && !stall_ID) begin
        check("rnd_pcv", pcValue_IF, exp_pc);
        check("rnd_exc", 32'(ExcCode_out), is_bad(exp_pc) ? 32'd4 : 32'd0);
        check("rnd_instr", Instr_IF, is_bad(exp_pc) ? 32'h0 : mem_word(exp_pc));
        delivered++;
        if (!(flush || epc_WE)) begin
          if (NPCOp_ID != 2'b00) begin
            m_pend = 1'b1;
            m_tgt = npcValue_ID;
            exp_pc = pcValue_IF + 32'd4;
          end else if (m_pend) begin
            exp_pc = m_tgt;
            m_pend = 1'b0;
          end else begin
            exp_pc = pcValue_IF + 32'd4;
          end
        end
      end
      if (flush || epc_WE) begin
        exp_pc = epc_WE ? epcValue_MEM : 32'h4180;
        m_pend = 1'b0;
      end
      @(negedge clk);
    end
    n_total++;
    if (delivered >= 300) n_pass++;
    else $display("FAIL rnd_progress: got %0d deliveries expected at least 300", delivered);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
